rol32_seq: RTL
==============

Name: rol32_seq

Overview:
- Multi-cycle rotate-left unit. It is the opposite-direction counterpart to the team's 32-bit rotate-right ALU function.
- Rotates a 32-bit operand left by num_shifts mod 32, one bit position per clock.
- Uses a start/busy/done handshake so the CPU control unit can stall on it.
- Sits in the phase-1 ALU datapath next to the shift/rotate units; result feeds the Z register mux.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a power of two.
- SHW, 5, shift-count bits used. Equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request strobe; accepted only in IDLE.
- in  input  WIDTH  operand; sampled on the accepting edge only.
- num_shifts  input  32  rotate amount; only bits [SHW-1:0] are used, upper bits ignored.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; high exactly while in DONE.
- out  output  WIDTH  result register; holds its value until the next accepted start or reset.

Behaviour:
- Reset: if clr=0 at an edge, state=IDLE, out=0, count=0, busy=0, done=0. This applies in any state, including mid-rotation; the partial result is discarded.
- Registered state: state (IDLE, SHIFT, DONE), count (SHW bits), out (WIDTH bits). busy and done are decoded from state only; no combinational path from inputs.
- IDLE:
  - On an edge with start=1: out<=in, count<=num_shifts[SHW-1:0].
  - Next state is SHIFT if that count is nonzero, else DONE.
  - With start=0: hold all registers.
- SHIFT:
  - Each edge: out<={out[WIDTH-2:0], out[WIDTH-1]}, count<=count-1.
  - If count==1 before the edge, next state is DONE; otherwise stay in SHIFT.
- DONE: the next edge always returns to IDLE; out is held.
- Latency: start accepted at edge k with n=num_shifts mod 32.
  - done is high during the cycle after edge k+n; for n=0 that is the cycle after edge k.
  - Back in IDLE after edge k+n+1.
  - Throughput is one operation per n+2 cycles.
- start asserted while busy=1 is ignored. No queuing; in and num_shifts changes are ignored too.
- start held high across DONE: a new operation is accepted on the first IDLE edge.
- out is valid when done=1 and remains valid in IDLE until the next accepted start. At acceptance, out shows the unrotated operand.
- Shift-count boundaries:
  - n=0 yields out=in.
  - n=32, 64, etc. also yield out=in.
  - n=31 equals a rotate right by 1.
- No X propagation: count and out are always reset-defined.

Test Plan:
- Reset: hold clr=0 for 2 cycles with start=1 -> busy=0, done=0, out=0x00000000. Release clr -> operation accepted on first edge with clr=1.
- Basic rotates:
  - in=0x12345678, num_shifts=4 -> done high in the 5th cycle after the accept edge, out=0x23456781. busy is high for 5 cycles, then low.
  - in=0x80000001, num_shifts=1 -> out=0x00000003 with done one cycle after the rotate edge.
- Count boundaries:
  - num_shifts=0 with in=0xDEADBEEF -> done on the cycle right after accept, out=0xDEADBEEF.
  - num_shifts=32 -> same result.
  - num_shifts=36 with in=0x12345678 -> out=0x23456781, 4 rotate cycles.
  - num_shifts=0xFFFFFFFF -> treated as 31.
- Wrap: in=0x00000001, num_shifts=31 -> out=0x80000000 after 31 rotate cycles.
- Ignore while busy: start in=0x0000000F, n=8. Mid-operation, pulse start with in=0xFFFFFFFF, n=1 -> ignored; final out=0x00000F00, exactly one done pulse.
- Reset mid-operation: start in=0x00000001, n=20. Drive clr=0 at the 10th rotate edge -> next cycle state=IDLE, busy=0, out=0, no done pulse. A following start with n=2 gives out=0x00000004.

Source files
------------

// File: rtl/rol32_seq.sv
// rol32_seq: multi-cycle rotate-left unit, one bit per clock, start/busy/done handshake
module rol32_seq #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      num_shifts,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [SHW-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic unused_hi;
  assign unused_hi = ^num_shifts[31:SHW];
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (start) begin
        out_d = in;
        count_d = num_shifts[SHW-1:0];
        state_d = |num_shifts[SHW-1:0] ? SHIFT : DONE;
      end
      SHIFT: begin
        out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        count_d = count_q - 1'b1;
        state_d = count_q == SHW'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      count_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q <= out_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign out = out_q;
endmodule
